// File: rtl/sr_cmd_pkg.sv
// Shared types and helpers for the SR flop-bank command generator.
// Holds the FSM state encoding, the pulse-length ceiling and the per-bit excitation rule.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sr_cmd_state_t;

  localparam int SR_PULSE_MAX = 255;

  typedef struct packed {
    logic set_mask;
    logic clr_mask;
  } sr_excite_t;

  // SR excitation for one flop: set only bits that must rise, reset only bits that must fall.
  function automatic sr_excite_t sr_excite(input logic target, input logic shadow);
    sr_excite_t v;
    v.set_mask = target & ~shadow;
    v.clr_mask = ~target & shadow;
    return v;
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that times the S/R excitation pulse.
// Raises o_expire during the last cycle of the loaded interval, then goes idle.
module sr_pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;
  logic             r_active;

  // Counts i_loadVal down to zero; the cycle spent at zero is the expiry cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_loadVal;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_expire = r_active && (r_count == '0);

endmodule

// File: rtl/sr_cmd_gen.sv
// Command-side driver for a bank of SR flops: turns a target Q vector into timed S/R pulses.
// Define SR_READBACK_CHECK_EN to add a Q readback compare (err) after each changing command.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [N_BITS-1:0] tgt_data,
  output logic [N_BITS-1:0] s_out,
  output logic [N_BITS-1:0] r_out,
  input  logic [N_BITS-1:0] q_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Out-of-range pulse lengths are clamped to the legal 1..SR_PULSE_MAX window.
  localparam int PULSE_EFF = (PULSE_CYC < 1) ? 1 :
                             ((PULSE_CYC > SR_PULSE_MAX) ? SR_PULSE_MAX : PULSE_CYC);
  localparam int TMR_W = $clog2(PULSE_EFF + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PULSE_EFF - 1);

  sr_cmd_state_t r_state, w_stateNext;

  logic [N_BITS-1:0] r_sOut, r_rOut;
  logic [N_BITS-1:0] r_shadow, r_tgtQ;
  logic              r_done, r_tgtReady, r_busy;

  logic [N_BITS-1:0] w_setMask, w_clrMask;
  logic [N_BITS-1:0] w_sNext, w_rNext, w_shadowNext;
  logic              w_doneNext, w_load, w_latch, w_expire;
  sr_excite_t        w_exc;

  always_comb begin
    w_setMask = '0;
    w_clrMask = '0;
    w_exc     = '0;
    for (int i = 0; i < N_BITS; i++) begin
      w_exc        = sr_excite(tgt_data[i], r_shadow[i]);
      w_setMask[i] = w_exc.set_mask;
      w_clrMask[i] = w_exc.clr_mask;
    end
  end

  sr_pulse_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_loadVal(TMR_LOAD),
    .o_expire (w_expire)
  );

`ifdef SR_READBACK_CHECK_EN
  logic r_err, w_errNext;
`else
  logic w_unused;
  assign w_unused = ^q_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // S/R masks are captured once at acceptance and simply held through DRIVE.
  always_comb begin
    w_stateNext  = r_state;
    w_sNext      = '0;
    w_rNext      = '0;
    w_doneNext   = 1'b0;
    w_load       = 1'b0;
    w_latch      = 1'b0;
    w_shadowNext = r_shadow;
`ifdef SR_READBACK_CHECK_EN
    w_errNext    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (tgt_valid && r_tgtReady) begin
          w_latch = 1'b1;
          if ((w_setMask == '0) && (w_clrMask == '0)) begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext = DRIVE;
            w_load      = 1'b1;
            w_sNext     = w_setMask;
            w_rNext     = w_clrMask;
          end
        end
      end
      DRIVE: begin
        if (w_expire) begin
          w_shadowNext = r_tgtQ;
`ifdef SR_READBACK_CHECK_EN
          w_stateNext  = CHECK;
`else
          w_stateNext  = DONE;
          w_doneNext   = 1'b1;
`endif
        end else begin
          w_sNext = r_sOut;
          w_rNext = r_rOut;
        end
      end
`ifdef SR_READBACK_CHECK_EN
      CHECK: begin
        w_stateNext = DONE;
        w_doneNext  = 1'b1;
        // Trust the real bank over our model when they disagree.
        if (q_in != r_tgtQ) begin
          w_errNext    = 1'b1;
          w_shadowNext = q_in;
        end
      end
`endif
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sOut     <= '0;
      r_rOut     <= '0;
      r_done     <= 1'b0;
      r_tgtReady <= 1'b1;
      r_busy     <= 1'b0;
      r_shadow   <= '0;
      r_tgtQ     <= '0;
    end else begin
      r_sOut     <= w_sNext;
      r_rOut     <= w_rNext;
      r_done     <= w_doneNext;
      r_tgtReady <= (w_stateNext == IDLE);
      r_busy     <= (w_stateNext != IDLE);
      r_shadow   <= w_shadowNext;
      if (w_latch) begin
        r_tgtQ <= tgt_data;
      end
    end
  end

`ifdef SR_READBACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_errNext;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign s_out     = r_sOut;
  assign r_out     = r_rOut;
  assign done      = r_done;
  assign busy      = r_busy;
  assign tgt_ready = r_tgtReady;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: directed steps plus randomized commands.
// Expected S/R, latency and shadow come from a command-level model of the SR bank.
module tb_sr_cmd_gen;

  localparam int NB = 8;
  localparam int P  = 2;
`ifdef SR_READBACK_CHECK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk;
  logic          rst;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [NB-1:0] tgt_data;
  logic [NB-1:0] s_out;
  logic [NB-1:0] r_out;
  logic [NB-1:0] q_in;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] shadowM;
  logic [NB-1:0] bankQ;
  logic          forceQ;
  logic [NB-1:0] forceVal;

  sr_cmd_gen #(
    .N_BITS   (NB),
    .PULSE_CYC(P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_data (tgt_data),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SR flop bank fed by the DUT, with an override for readback faults.
  always @(posedge clk) begin
    if (rst) bankQ <= '0;
    else     bankQ <= (bankQ & ~r_out) | s_out;
  end
  assign q_in = forceQ ? forceVal : bankQ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] tgt);
    int waitCyc = 0;
    while (tgt_ready !== 1'b1 && waitCyc < 50) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    check("ready_before_accept", {31'd0, tgt_ready}, 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input int k, input int lat, input bit change,
                             input logic [NB-1:0] setE, input logic [NB-1:0] clrE,
                             input bit errE);
    bit inPulse;
    inPulse = change && (k <= P);
    check($sformatf("s_out@A+%0d", k), s_out, inPulse ? setE : '0);
    check($sformatf("r_out@A+%0d", k), r_out, inPulse ? clrE : '0);
    check($sformatf("s_and_r@A+%0d", k), s_out & r_out, 32'd0);
    check($sformatf("done@A+%0d", k), {31'd0, done}, {31'd0, (k == lat)});
    check($sformatf("err@A+%0d", k), {31'd0, err}, {31'd0, (k == lat) && errE});
    check($sformatf("busy@A+%0d", k), {31'd0, busy}, {31'd0, (k <= lat)});
    check($sformatf("ready@A+%0d", k), {31'd0, tgt_ready}, {31'd0, (k > lat)});
  endtask

  task automatic runCommand(input logic [NB-1:0] tgt, input bit hold);
    logic [NB-1:0] setE, clrE, qSeen;
    bit change, errE;
    int lat;
    setE   = tgt & ~shadowM;
    clrE   = ~tgt & shadowM;
    change = ((setE | clrE) != '0);
    lat    = change ? (P + 1 + EXTRA) : 1;
    qSeen  = forceQ ? forceVal : tgt;
    errE   = (EXTRA == 1) && change && (qSeen != tgt);
    applyStimulus(tgt);
    if (!hold) tgt_valid = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (hold) tgt_data = NB'($urandom);
      checkOutput(k, lat, change, setE, clrE, errE);
      if (k <= lat) begin
        @(posedge clk); #1;
      end
    end
    shadowM = errE ? qSeen : tgt;
  endtask

  initial begin
    logic [NB-1:0] abortTgt;
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    forceQ    = 1'b0;
    forceVal  = '0;
    shadowM   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_out", s_out, 32'd0);
    check("reset_r_out", r_out, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, tgt_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    runCommand(8'hA5, 1'b0);
    runCommand(8'h5A, 1'b0);
    runCommand(8'h5A, 1'b0);
    runCommand(8'hC3, 1'b1);
    runCommand(8'h0F, 1'b0);

    // Abort on the second DRIVE cycle.
    abortTgt = ~shadowM;
    applyStimulus(abortTgt);
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_s_mid", s_out, abortTgt & ~shadowM);
    check("abort_r_mid", r_out, ~abortTgt & shadowM);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_s_out", s_out, 32'd0);
    check("abort_r_out", r_out, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, tgt_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    shadowM = '0;
    runCommand(8'hA5, 1'b0);

`ifdef SR_READBACK_CHECK_EN
    forceQ   = 1'b1;
    forceVal = 8'hFE;
    runCommand(8'hFF, 1'b0);
    forceQ   = 1'b0;
    runCommand(8'hFF, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      logic [NB-1:0] t;
      t = ($urandom_range(0, 3) == 0) ? shadowM : NB'($urandom);
      runCommand(t, ($urandom_range(0, 3) == 0));
    end
    tgt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_idle_ready", {31'd0, tgt_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
